uart_rx_frame_check: RTL and testbench

Parametrised receive-side frame checker for the UART Rx path, one level up from the single start-bit glitch check. It consumes one oversampled bit per strobe from the data sampler and walks the frame through start, data, optional parity and stop bits. Each frame yields a checked data word or one-cycle error flags: start glitch, parity error, stop error. Saturating per-error counters give the register file a diagnostic view of line quality.

---
 rtl/uart_rx_frame_check.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: walks start, data, optional parity and stop bits
// from oversampled bit strobes and reports the data word or per-frame errors.
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic inc, input logic clr);
    if (clr) begin
      return {CNT_WIDTH{1'b0}};
    end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
      return cnt + CNT_WIDTH'(1);
    end else begin
      return cnt;
    end
  endfunction

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [2:0]            state_r;
  logic [2:0]            next_state_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic [1:0]            stop_cnt_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  par_lat_r;
  logic                  stp_lat_r;

  logic glitch_s;
  logic last_data_s;
  logic last_stop_s;
  logic stp_fin_s;

  assign glitch_s    = (state_r == START) && bit_valid && sampled_bit;
  assign last_data_s = (state_r == DATA) && bit_valid && (bit_cnt_r == BCW'(DATA_WIDTH - 1));
  assign last_stop_s = (state_r == STOP) && bit_valid && (stop_cnt_r == 2'(STOP_BITS - 1));
  // The final stop bit has not reached the latch yet, so fold it in here.
  assign stp_fin_s   = stp_lat_r | ~sampled_bit;

  // Next-state decode for the frame walker.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:   if (frame_start) next_state_s = START; else next_state_s = state_r;
      START:  if (bit_valid) next_state_s = sampled_bit ? IDLE : DATA; else next_state_s = state_r;
      DATA:   if (last_data_s) next_state_s = par_en_r ? PARITY : STOP; else next_state_s = state_r;
      PARITY: if (bit_valid) next_state_s = STOP; else next_state_s = state_r;
      STOP:   if (last_stop_s) next_state_s = IDLE; else next_state_s = state_r;
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath, result pulses and saturating counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      shift_r     <= {DATA_WIDTH{1'b0}};
      bit_cnt_r   <= {BCW{1'b0}};
      stop_cnt_r  <= 2'd0;
      par_en_r    <= 1'b0;
      par_typ_r   <= 1'b0;
      par_lat_r   <= 1'b0;
      stp_lat_r   <= 1'b0;
      data_out    <= {DATA_WIDTH{1'b0}};
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      glitch_cnt  <= {CNT_WIDTH{1'b0}};
      par_err_cnt <= {CNT_WIDTH{1'b0}};
      stp_err_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= next_state_s;
      busy        <= (next_state_s != IDLE);
      strt_glitch <= glitch_s;
      data_valid  <= last_stop_s && !(par_lat_r || stp_fin_s);
      par_err     <= last_stop_s && par_lat_r;
      stp_err     <= last_stop_s && stp_fin_s;
      glitch_cnt  <= sat_inc(glitch_cnt, glitch_s, clr_cnt);
      par_err_cnt <= sat_inc(par_err_cnt, last_stop_s && par_lat_r, clr_cnt);
      stp_err_cnt <= sat_inc(stp_err_cnt, last_stop_s && stp_fin_s, clr_cnt);
      if (last_stop_s) begin
        data_out <= shift_r;
      end
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            par_en_r   <= par_en;
            par_typ_r  <= par_typ;
            par_lat_r  <= 1'b0;
            stp_lat_r  <= 1'b0;
            bit_cnt_r  <= {BCW{1'b0}};
            stop_cnt_r <= 2'd0;
          end
        end
        START: begin
          if (bit_valid) begin
            bit_cnt_r <= {BCW{1'b0}};
          end
        end
        DATA: begin
          stop_cnt_r <= 2'd0;
          if (bit_valid) begin
            shift_r   <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};
            bit_cnt_r <= bit_cnt_r + BCW'(1);
          end
        end
        PARITY: begin
          stop_cnt_r <= 2'd0;
          if (bit_valid && (sampled_bit != parity_of(shift_r, par_typ_r))) begin
            par_lat_r <= 1'b1;
          end
        end
        STOP: begin
          if (last_stop_s) begin
            par_lat_r  <= 1'b0;
            stp_lat_r  <= 1'b0;
            stop_cnt_r <= 2'd0;
          end else if (bit_valid) begin
            stop_cnt_r <= stop_cnt_r + 2'd1;
            if (!sampled_bit) begin
              stp_lat_r <= 1'b1;
            end
          end
        end
        default: begin
          par_lat_r <= 1'b0;
          stp_lat_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench: directed frames plus randomized frames on two instances
// (1 stop bit / 8-bit counters, and 2 stop bits / 2-bit counters).
module tb_uart_rx_frame_check;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic frame_start = 1'b0;
  logic bit_valid = 1'b0;
  logic sampled_bit = 1'b1;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic clr_cnt = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic       busy0, dv0, g0, pe0, se0;
  logic [7:0] d0, gc0, pc0, sc0;
  logic       busy1, dv1, g1, pe1, se1;
  logic [7:0] d1;
  logic [1:0] gc1, pc1, sc1;

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) u0 (
    .CLK(clk), .RST(rst),
    .frame_start(frame_start & ~sel), .bit_valid(bit_valid & ~sel),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .clr_cnt(clr_cnt & ~sel),
    .busy(busy0), .data_out(d0), .data_valid(dv0), .strt_glitch(g0),
    .par_err(pe0), .stp_err(se0),
    .glitch_cnt(gc0), .par_err_cnt(pc0), .stp_err_cnt(sc0)
  );

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) u1 (
    .CLK(clk), .RST(rst),
    .frame_start(frame_start & sel), .bit_valid(bit_valid & sel),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
    .clr_cnt(clr_cnt & sel),
    .busy(busy1), .data_out(d1), .data_valid(dv1), .strt_glitch(g1),
    .par_err(pe1), .stp_err(se1),
    .glitch_cnt(gc1), .par_err_cnt(pc1), .stp_err_cnt(sc1)
  );

  // Reference state per instance: last good/bad word and counter values.
  int m_data [2];
  int m_gcnt [2];
  int m_pcnt [2];
  int m_scnt [2];

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  function automatic int cmax();
    return (sel == 1'b1) ? 3 : 255;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (inst %0d): observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input logic clr);
    sampled_bit = b;
    bit_valid   = 1'b1;
    clr_cnt     = clr;
    cyc();
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  // Idle cycles between strobes, sometimes with a stray frame_start.
  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      frame_start = ($urandom_range(0, 5) == 0);
      cyc();
      frame_start = 1'b0;
    end
  endtask

  task automatic check_out(input string tag, input int dv, input int gl, input int pe, input int se);
    int s;
    s = (sel == 1'b1) ? 1 : 0;
    check({tag, "_data_valid"}, sel ? dv1 : dv0, dv);
    check({tag, "_data_out"}, sel ? d1 : d0, m_data[s]);
    check({tag, "_strt_glitch"}, sel ? g1 : g0, gl);
    check({tag, "_par_err"}, sel ? pe1 : pe0, pe);
    check({tag, "_stp_err"}, sel ? se1 : se0, se);
    check({tag, "_glitch_cnt"}, sel ? {6'd0, gc1} : gc0, m_gcnt[s]);
    check({tag, "_par_err_cnt"}, sel ? {6'd0, pc1} : pc0, m_pcnt[s]);
    check({tag, "_stp_err_cnt"}, sel ? {6'd0, sc1} : sc0, m_scnt[s]);
    check({tag, "_busy"}, sel ? busy1 : busy0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 0; m_gcnt[i] = 0; m_pcnt[i] = 0; m_scnt[i] = 0;
    end
  endtask

  // One frame on the selected instance; stops[0] is the first stop bit.
  task automatic run_frame(input string tag, input logic start_b, input logic [7:0] d,
                           input logic pe, input logic pt, input logic pbit,
                           input logic [1:0] stops, input logic clr);
    int s, nstop;
    logic exp_pe, exp_se;
    s = (sel == 1'b1) ? 1 : 0;
    nstop = (sel == 1'b1) ? 2 : 1;
    frame_start = 1'b1; par_en = pe; par_typ = pt;
    cyc();
    frame_start = 1'b0; par_en = $urandom_range(0, 1); par_typ = $urandom_range(0, 1);
    check({tag, "_busy_in_frame"}, sel ? busy1 : busy0, 1);
    gap();
    if (start_b) begin
      strobe(1'b1, clr);
      if (clr) begin
        m_gcnt[s] = 0; m_pcnt[s] = 0; m_scnt[s] = 0;
      end else begin
        m_gcnt[s] = sat(m_gcnt[s], cmax());
      end
      check_out(tag, 0, 1, 0, 0);
    end else begin
      strobe(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        gap();
        strobe(d[i], 1'b0);
      end
      if (pe) begin
        gap();
        strobe(pbit, 1'b0);
      end
      for (int k = 0; k < nstop; k++) begin
        gap();
        strobe(stops[k], 1'b0);
      end
      exp_pe = pe && (pbit != ((^d) ^ pt));
      exp_se = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
      m_data[s] = d;
      if (exp_pe) m_pcnt[s] = sat(m_pcnt[s], cmax());
      if (exp_se) m_scnt[s] = sat(m_scnt[s], cmax());
      check_out(tag, (!exp_pe && !exp_se) ? 1 : 0, 0, exp_pe, exp_se);
    end
    cyc();
    check({tag, "_pulse_end"}, sel ? {dv1, g1, pe1, se1} : {dv0, g0, pe0, se0}, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pe, pt, pbit, sb;
    logic [1:0] st;

    model_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    sel = 1'b0; check_out("reset0", 0, 0, 0, 0);
    sel = 1'b1; check_out("reset1", 0, 0, 0, 0);

    sel = 1'b0;
    run_frame("clean_a5", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    run_frame("glitch", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    run_frame("clean_3c", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    run_frame("even_bad", 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
    run_frame("even_good", 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);

    sel = 1'b1;
    run_frame("stop2_bad", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    run_frame("odd_and_stop", 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) run_frame("sat_glitch", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    run_frame("clr_glitch", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1);

    // Reset in the middle of the data bits.
    sel = 1'b0;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1)), 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    check_out("mid_reset", 0, 0, 0, 0);
    cyc();
    check_out("after_reset", 0, 0, 0, 0);
    run_frame("clean_ff", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);

    for (int k = 0; k < 60; k++) begin
      sel  = 1'(k % 2);
      sb   = ($urandom_range(0, 5) == 0);
      d    = 8'($urandom);
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      pbit = (^d) ^ pt ^ ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      run_frame("random", sb, d, pe, pt, pbit, st, 1'b0);
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
